// File: rtl/rv_decode_pkg.sv
// rtl/rv_decode_pkg.sv - RV32/RV64 decode types, opcode constants and the pure field/immediate decoder
package rv_decode_pkg;

    localparam int XLEN_MAX = 64;

    typedef logic [XLEN_MAX-1:0] rv_imm_t;

    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_IMM_32   = 7'b0011011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_32       = 7'b0111011;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE} rv_imm_type_e;

    // imm is XLEN_MAX wide; for an RV32 build the bits above 31 are zero.
    typedef struct packed {
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [11:0] funct12;
        rv_imm_t     imm;
        logic        decode_error;
    } rv_fields_t;

    function automatic rv_fields_t rv_decode(input logic [31:0] inst, input logic xlen64, input logic m_en);
        rv_fields_t   f;
        rv_imm_type_e t;
        logic         legal;
        logic         f7_ok;
        logic [31:0]  imm32;
        f         = '0;
        f.inst    = inst;
        f.opcode  = inst[6:0];
        f.rd      = inst[11:7];
        f.funct3  = inst[14:12];
        f.rs1     = inst[19:15];
        f.rs2     = inst[24:20];
        f.funct7  = inst[31:25];
        f.funct12 = inst[31:20];
        f7_ok = (f.funct7 == F7_BASE) || (f.funct7 == F7_ALT) || (m_en && (f.funct7 == F7_MULDIV));
        legal = 1'b1;
        t     = IMM_NONE;
        case (f.opcode)
            OP_LOAD, OP_IMM, OP_JALR, OP_MISC_MEM, OP_SYSTEM: t = IMM_I;
            OP_IMM_32: begin t = IMM_I; legal = xlen64; end
            OP_STORE:  t = IMM_S;
            OP_BRANCH: t = IMM_B;
            OP_LUI, OP_AUIPC: t = IMM_U;
            OP_JAL:    t = IMM_J;
            OP_OP:     legal = f7_ok;
            OP_32:     legal = xlen64 && f7_ok;
            default:   legal = 1'b0;
        endcase
        if (inst[1:0] != 2'b11) legal = 1'b0;
        case (t)
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
        if (!legal) imm32 = '0;
        f.imm          = xlen64 ? {{32{imm32[31]}}, imm32} : {32'b0, imm32};
        f.decode_error = !legal;
        return f;
    endfunction

endpackage

// File: rtl/rv_stream_fifo.sv
// rtl/rv_stream_fifo.sv - generic DEPTH x WIDTH valid/ready FIFO with synchronous flush
module rv_stream_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [AW:0]      w_count_nxt;

    assign w_push = in_valid && r_in_ready && !flush;
    assign w_pop  = (r_count != '0) && out_ready && !flush;

    always_comb begin
        w_count_nxt = r_count;
        if (flush) w_count_nxt = '0;
        else       w_count_nxt = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end

    // Memory is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_in_ready <= 1'b1;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr_ptr] <= in_data;
                    r_wr_ptr        <= r_wr_ptr + PTR_ONE;
                end
                if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_count    <= w_count_nxt;
            r_in_ready <= (w_count_nxt != FULL);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];

endmodule

// File: rtl/rv_decode_queue.sv
// rtl/rv_decode_queue.sv - RV32/RV64 decode stage feeding a record FIFO; RV_DECODE_STATS_EN adds push/illegal counters
module rv_decode_queue
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int M_EN  = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output rv_fields_t      out_fields,
    output logic [XLEN-1:0] out_pc,
    input  logic            flush
`ifdef RV_DECODE_STATS_EN
    ,
    output logic [31:0]     stat_decoded,
    output logic [31:0]     stat_illegal
`endif
);
    localparam int REC_W = XLEN + $bits(rv_fields_t);

    rv_fields_t       w_fields;
    logic [REC_W-1:0] w_out_rec;

    assign w_fields = rv_decode(in_inst, XLEN == 64, M_EN != 0);

    rv_stream_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_pc, w_fields}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (w_out_rec)
    );

    assign {out_pc, out_fields} = w_out_rec;

`ifdef RV_DECODE_STATS_EN
    logic        w_push;
    logic [31:0] r_stat_decoded;
    logic [31:0] r_stat_illegal;

    assign w_push = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_decoded <= '0;
            r_stat_illegal <= '0;
        end else if (flush) begin
            r_stat_decoded <= '0;
            r_stat_illegal <= '0;
        end else if (w_push) begin
            if (r_stat_decoded != '1) r_stat_decoded <= r_stat_decoded + 32'd1;
            if (w_fields.decode_error && (r_stat_illegal != '1)) r_stat_illegal <= r_stat_illegal + 32'd1;
        end
    end

    assign stat_decoded = r_stat_decoded;
    assign stat_illegal = r_stat_illegal;
`endif

endmodule
